regfile_sb: RTL and testbench

- Parametrised successor to the 8-entry GPR file.
- Configurable data width, register count and read-port count; two write ports, A for pipeline writeback and B for long-latency unit return (mult/div/load miss).
- Per-register pending scoreboard, optional write-to-read bypass, error flags.
- Sits between decode/issue (reads, reservations) and writeback/long-latency units (writes).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_if.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_NUM_RD = 2;

    // Register 0 is hardwired to zero and never reserved.
    localparam int unsigned REG_ZERO = 0;

    // Bit offset of port 'port' inside a packed multi-port bus of 'width'-bit lanes.
    function automatic int unsigned slice_off(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, write, reservation and status signals around the register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned CNT_W  = ADDR_W + 1
);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;

    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;

    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;

    logic [NUM_REGS-1:0]      pending;
    logic [CNT_W-1:0]         pend_cnt;
    logic                     wr_conflict;
    logic                     rsv_err;
    logic                     wb_err;

    // Issue/writeback side drives requests and observes the file.
    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, pending, pend_cnt, wr_conflict, rsv_err, wb_err
    );

    // Register file side.
    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, pending, pend_cnt, wr_conflict, rsv_err, wb_err
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard with incremental population count and error pulses.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic [CNT_W-1:0]         pend_cnt,
    output logic                     rsv_err,
    output logic                     wb_err
);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_next;
    logic [CNT_W-1:0]    cnt_next;
    logic                rsv_hit;
    logic                wb_hit;
    logic                same_reg;
    logic                inc;
    logic                dec;
    logic                rsv_err_next;
    logic                wb_err_next;

    // Next pending vector: a new reservation beats a same-cycle return to the same register.
    always_comb begin
        pending_next = pending;
        inc          = 1'b0;
        dec          = 1'b0;
        rsv_hit      = rsv_en && (rsv_addr != ZERO_ADDR);
        wb_hit       = wb_en && (wb_addr != ZERO_ADDR);
        same_reg     = rsv_hit && wb_hit && (rsv_addr == wb_addr);
        if (wb_hit && !same_reg) begin
            pending_next[wb_addr] = 1'b0;
            dec                   = pending[wb_addr];
        end
        if (rsv_hit) begin
            pending_next[rsv_addr] = 1'b1;
            inc                    = !pending[rsv_addr];
        end
        cnt_next     = pend_cnt + CNT_W'(inc) - CNT_W'(dec);
        rsv_err_next = rsv_hit && pending[rsv_addr] && !same_reg;
        wb_err_next  = wb_hit && !pending[wb_addr];
    end

    // Scoreboard state and single-cycle error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
            rsv_err  <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
            rsv_err  <= rsv_err_next;
            wb_err   <= wb_err_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with pending scoreboard and optional write bypass.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [NUM_REGS-1:0]      pending;
    logic [CNT_W-1:0]         pend_cnt;
    logic                     rsv_err;
    logic                     wb_err;
    logic                     wr_conflict;
    logic                     wa_hit;
    logic                     wb_hit;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;

    assign wa_hit = bus.wa_en && (bus.wa_addr != ZERO_ADDR);
    assign wb_hit = bus.wb_en && (bus.wb_addr != ZERO_ADDR);

    // Storage: port A wins over port B on the same register; register 0 stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (wa_hit && (bus.wa_addr == ADDR_W'(r))) begin
                    regs[r] <= bus.wa_data;
                end else if (wb_hit && (bus.wb_addr == ADDR_W'(r))) begin
                    regs[r] <= bus.wb_data;
                end
            end
        end
    end

    // Flag a same-register collision between the two write ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= wa_hit && wb_hit && (bus.wa_addr == bus.wb_addr);
        end
    end

    // Zero-latency read ports with optional forwarding of this cycle's write data.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = bus.rd_addr[slice_off(i, ADDR_W) +: ADDR_W];
            if (ra != ZERO_ADDR) begin
                rd_data_c[slice_off(i, DATA_W) +: DATA_W] = regs[ra];
                rd_busy_c[i] = pending[ra];
                if (BYPASS != 0) begin
                    if (wa_hit && (bus.wa_addr == ra)) begin
                        rd_data_c[slice_off(i, DATA_W) +: DATA_W] = bus.wa_data;
                    end else if (wb_hit && (bus.wb_addr == ra)) begin
                        rd_data_c[slice_off(i, DATA_W) +: DATA_W] = bus.wb_data;
                    end
                    if (wb_hit && (bus.wb_addr == ra)) begin
                        rd_busy_c[i] = 1'b0;
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .wb_en    (bus.wb_en),
        .wb_addr  (bus.wb_addr),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .rsv_err  (rsv_err),
        .wb_err   (wb_err)
    );

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.pending     = pending;
    assign bus.pend_cnt    = pend_cnt;
    assign bus.rsv_err     = rsv_err;
    assign bus.wb_err      = wb_err;
    assign bus.wr_conflict = wr_conflict;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: bypass and non-bypass instances driven with identical stimulus.
module tb_regfile_sb;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned NR   = 2;
    localparam int unsigned NREG = 8;
    localparam int unsigned CW   = 4;

    typedef struct {
        logic [NR*DW-1:0] rd1;
        logic [NR*DW-1:0] rd0;
        logic [NR-1:0]    busy1;
        logic [NR-1:0]    busy0;
        logic [NREG-1:0]  pend;
        logic [CW-1:0]    cnt;
        logic             conf;
        logic             rerr;
        logic             werr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .bus(bus1));
    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset), .bus(bus0));

    assign bus0.rd_addr  = bus1.rd_addr;
    assign bus0.wa_en    = bus1.wa_en;
    assign bus0.wa_addr  = bus1.wa_addr;
    assign bus0.wa_data  = bus1.wa_data;
    assign bus0.wb_en    = bus1.wb_en;
    assign bus0.wb_addr  = bus1.wb_addr;
    assign bus0.wb_data  = bus1.wb_data;
    assign bus0.rsv_en   = bus1.rsv_en;
    assign bus0.rsv_addr = bus1.rsv_addr;

    // Reference model state.
    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_pend;
    logic            m_conf, m_rerr, m_werr;

    exp_t expq [$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && bus1.wa_en && bus1.wa_addr == a) return bus1.wa_data;
        if (byp && bus1.wb_en && bus1.wb_addr == a) return bus1.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && bus1.wb_en && bus1.wb_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    // Push this cycle's expected outputs, advance the model across the edge, move to next cycle.
    task automatic tick();
        exp_t e;
        logic [AW-1:0] a;
        logic [AW-1:0] wa, wb, ra;
        if (reset) begin
            for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            m_pend = '0;
            m_conf = 1'b0;
            m_rerr = 1'b0;
            m_werr = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            a = bus1.rd_addr[i*AW +: AW];
            e.rd1[i*DW +: DW] = exp_rd(a, 1'b1);
            e.rd0[i*DW +: DW] = exp_rd(a, 1'b0);
            e.busy1[i] = exp_busy(a, 1'b1);
            e.busy0[i] = exp_busy(a, 1'b0);
        end
        e.pend = m_pend;
        e.cnt  = CW'($countones(m_pend));
        e.conf = m_conf;
        e.rerr = m_rerr;
        e.werr = m_werr;
        expq.push_back(e);
        if (!reset) begin
            wa = bus1.wa_addr;
            wb = bus1.wb_addr;
            ra = bus1.rsv_addr;
            m_conf = bus1.wa_en && bus1.wb_en && wa == wb && wa != 0;
            m_rerr = bus1.rsv_en && ra != 0 && m_pend[ra] && !(bus1.wb_en && wb == ra);
            m_werr = bus1.wb_en && wb != 0 && !m_pend[wb];
            if (bus1.wb_en && wb != 0) m_regs[wb] = bus1.wb_data;
            if (bus1.wa_en && wa != 0) m_regs[wa] = bus1.wa_data;
            if (bus1.wb_en && wb != 0) m_pend[wb] = 1'b0;
            if (bus1.rsv_en && ra != 0) m_pend[ra] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r0);
        bus1.rd_addr = {r1, r0};
        bus1.wa_en = 1'b0; bus1.wa_addr = '0; bus1.wa_data = '0;
        bus1.wb_en = 1'b0; bus1.wb_addr = '0; bus1.wb_data = '0;
        bus1.rsv_en = 1'b0; bus1.rsv_addr = '0;
    endtask

    task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.wa_en = 1'b1; bus1.wa_addr = a; bus1.wa_data = d;
    endtask

    task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.wb_en = 1'b1; bus1.wb_addr = a; bus1.wb_data = d;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        bus1.rsv_en = 1'b1; bus1.rsv_addr = a;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rd_data_byp",  32'(bus1.rd_data),     32'(e.rd1));
            chk("rd_busy_byp",  32'(bus1.rd_busy),     32'(e.busy1));
            chk("pending_byp",  32'(bus1.pending),     32'(e.pend));
            chk("pend_cnt_byp", 32'(bus1.pend_cnt),    32'(e.cnt));
            chk("conflict_byp", 32'(bus1.wr_conflict), 32'(e.conf));
            chk("rsv_err_byp",  32'(bus1.rsv_err),     32'(e.rerr));
            chk("wb_err_byp",   32'(bus1.wb_err),      32'(e.werr));
            chk("rd_data_nob",  32'(bus0.rd_data),     32'(e.rd0));
            chk("rd_busy_nob",  32'(bus0.rd_busy),     32'(e.busy0));
            chk("pending_nob",  32'(bus0.pending),     32'(e.pend));
            chk("pend_cnt_nob", 32'(bus0.pend_cnt),    32'(e.cnt));
            chk("conflict_nob", 32'(bus0.wr_conflict), 32'(e.conf));
            chk("rsv_err_nob",  32'(bus0.rsv_err),     32'(e.rerr));
            chk("wb_err_nob",   32'(bus0.wb_err),      32'(e.werr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle(3'd0, 3'd0);
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // Reads of every address after reset.
        for (int a = 0; a < NREG; a++) begin
            idle(3'(7 - a), 3'(a));
            tick();
        end

        // Port A write with bypass, then visibility next cycle; register 0 stays 0.
        idle(3'd0, 3'd3); wr_a(3'd3, 16'hBEEF); tick();
        idle(3'd0, 3'd3); tick();
        idle(3'd3, 3'd0); wr_a(3'd0, 16'hFFFF); tick();
        idle(3'd3, 3'd0); tick();

        // Same-register A/B collision, then distinct addresses.
        idle(3'd0, 3'd5); wr_a(3'd5, 16'h1111); wr_b(3'd5, 16'h2222); tick();
        idle(3'd0, 3'd5); tick();
        idle(3'd6, 3'd5); tick();
        idle(3'd6, 3'd5); wr_a(3'd5, 16'h3333); wr_b(3'd6, 16'h4444); tick();
        idle(3'd6, 3'd5); tick();

        // Reserve, double reserve, long-latency return.
        idle(3'd0, 3'd2); rsv(3'd2); tick();
        idle(3'd0, 3'd2); tick();
        idle(3'd0, 3'd2); rsv(3'd2); tick();
        idle(3'd0, 3'd2); tick();
        idle(3'd0, 3'd2); wr_b(3'd2, 16'h00AA); tick();
        idle(3'd0, 3'd2); tick();
        idle(3'd0, 3'd2); tick();

        // Return to a non-pending register; reserve and return together.
        idle(3'd4, 3'd4); wr_b(3'd4, 16'h0404); tick();
        idle(3'd4, 3'd4); rsv(3'd4); tick();
        idle(3'd4, 3'd4); rsv(3'd4); wr_b(3'd4, 16'h4040); tick();
        idle(3'd4, 3'd4); tick();
        idle(3'd4, 3'd4); tick();

        // Fill then drain the scoreboard.
        for (int r = 1; r < NREG; r++) begin
            idle(3'(r), 3'(r - 1)); rsv(3'(r)); tick();
        end
        idle(3'd7, 3'd1); tick();
        for (int r = 1; r < NREG; r++) begin
            idle(3'(r), 3'(8 - r)); wr_b(3'(r), 16'(r * 16'h0101)); tick();
        end
        idle(3'd7, 3'd1); tick();

        // Reset in the middle of a write and reservation.
        idle(3'd1, 3'd3); wr_a(3'd3, 16'h1234); wr_b(3'd1, 16'h5678); rsv(3'd6); tick();
        idle(3'd1, 3'd3); rsv(3'd1); reset = 1'b1; wr_a(3'd3, 16'hDEAD); tick();
        reset = 1'b0;
        idle(3'd1, 3'd3); tick();
        idle(3'd6, 3'd3); tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bus1.rd_addr  = 6'($urandom);
            bus1.wa_en    = ($urandom_range(0, 2) == 0);
            bus1.wa_addr  = 3'($urandom);
            bus1.wa_data  = 16'($urandom);
            bus1.wb_en    = ($urandom_range(0, 2) == 0);
            bus1.wb_addr  = 3'($urandom);
            bus1.wb_data  = 16'($urandom);
            bus1.rsv_en   = ($urandom_range(0, 1) == 0);
            bus1.rsv_addr = 3'($urandom);
            reset         = ($urandom_range(0, 96) == 0);
            tick();
        end
        reset = 1'b0;
        idle(3'd0, 3'd0); tick();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
